// File: rtl/divisor_peso.sv
// Price-to-weight divider: weight_g = round(precof * 1000 / centimos).
// Restoring division, one quotient bit per clock, start/busy/done handshake.
module divisor_peso #(
    parameter int PRECO_W = 19,
    parameter int CENT_W  = 12,
    parameter int PESO_W  = 12,
    parameter int DIV_W   = 29
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PRECO_W-1:0] precof,
    input  logic [CENT_W-1:0]  centimos,
    output logic [PESO_W-1:0]  weightInGrams,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              divZero
);

    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIVIDE,
        ROUND
    } state_t;

    state_t             state;
    logic [PRECO_W-1:0] preco_r;
    logic [CENT_W-1:0]  cent_r;
    logic [DIV_W-1:0]   dividend;
    logic [CENT_W:0]    rem;
    logic [DIV_W-1:0]   quo;
    logic [CNT_W-1:0]   cnt;

    logic [DIV_W-1:0]   px;
    logic [DIV_W-1:0]   prod;
    logic [CENT_W+1:0]  dvsr;
    logic [CENT_W+1:0]  rem_sh;
    logic [CENT_W+1:0]  rem_sub;
    logic               fits;
    logic [CENT_W+1:0]  rem_x2;
    logic [DIV_W:0]     q_rnd;
    logic [DIV_W:0]     q_max;

    // x*1000 = x*1024 - x*16 - x*8
    always_comb begin
        px      = DIV_W'(preco_r);
        prod    = (px << 10) - (px << 4) - (px << 3);
        dvsr    = {2'b00, cent_r};
        rem_sh  = {rem, dividend[DIV_W-1]};
        fits    = (rem_sh >= dvsr);
        rem_sub = rem_sh - dvsr;
        rem_x2  = {rem, 1'b0};
        q_rnd   = {1'b0, quo} + (DIV_W+1)'(rem_x2 >= dvsr);
        q_max   = (DIV_W+1)'((1 << PESO_W) - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            preco_r       <= '0;
            cent_r        <= '0;
            dividend      <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            weightInGrams <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            divZero       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        preco_r  <= precof;
                        cent_r   <= centimos;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        divZero  <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cent_r == '0) begin
                        weightInGrams <= '1;
                        divZero       <= 1'b1;
                        overflow      <= 1'b0;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        dividend <= prod;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= CNT_W'(DIV_W - 1);
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    dividend <= dividend << 1;
                    quo      <= {quo[DIV_W-2:0], fits};
                    rem      <= fits ? rem_sub[CENT_W:0] : rem_sh[CENT_W:0];
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) state <= ROUND;
                end
                ROUND: begin
                    if (q_rnd > q_max) begin
                        weightInGrams <= '1;
                        overflow      <= 1'b1;
                    end else begin
                        weightInGrams <= q_rnd[PESO_W-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_peso.sv
// Directed bench for divisor_peso: vector table plus busy-start and
// mid-operation reset sequences.
module tb_divisor_peso;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [18:0] precof = '0;
    logic [11:0] centimos = '0;
    logic [11:0] weightInGrams;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        divZero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divisor_peso dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .precof(precof),
        .centimos(centimos),
        .weightInGrams(weightInGrams),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .divZero(divZero)
    );

    typedef struct {
        logic [18:0] p;
        logic [11:0] c;
        logic [11:0] w;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait for done; returns edges from accept to done.
    task automatic run_op(input logic [18:0] p, input logic [11:0] c,
                          output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        precof = p;
        centimos = c;
        @(posedge clk);
        #1;
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        start = 1'b0;
        precof = $urandom;
        centimos = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    int   lat;
    logic bok;

    initial begin
        vecs[0] = '{19'd705,    12'd470,  12'd1500, 1'b0, 1'b0, 31};
        vecs[1] = '{19'd1,      12'd3,    12'd333,  1'b0, 1'b0, 31};
        vecs[2] = '{19'd2,      12'd3,    12'd667,  1'b0, 1'b0, 31};
        vecs[3] = '{19'd1,      12'd2000, 12'd1,    1'b0, 1'b0, 31};
        vecs[4] = '{19'd4095,   12'd1,    12'd4095, 1'b1, 1'b0, 31};
        vecs[5] = '{19'd524287, 12'd4095, 12'd4095, 1'b1, 1'b0, 31};
        vecs[6] = '{19'd100,    12'd0,    12'd4095, 1'b0, 1'b1, 1};
        vecs[7] = '{19'd4095,   12'd1000, 12'd4095, 1'b0, 1'b0, 31};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_w", weightInGrams, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dz", divZero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].p, vecs[i].c, lat, bok);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), bok, 1);
            chk($sformatf("v%0d_w", i), weightInGrams, vecs[i].w);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("v%0d_dz", i), divZero, vecs[i].dz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_drop", i), done, 0);
            chk($sformatf("v%0d_hold", i), weightInGrams, vecs[i].w);
        end

        // Start while busy: second request at E10 must be ignored.
        @(negedge clk);
        start = 1'b1;
        precof = 19'd705;
        centimos = 12'd470;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                start = 1'b1;
                precof = 19'd1;
                centimos = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_start_lat", lat, 31);
        chk("busy_start_w", weightInGrams, 1500);
        run_op(19'd1, 12'd3, lat, bok);
        chk("reissue_lat", lat, 31);
        chk("reissue_w", weightInGrams, 333);

        // Reset at E15 aborts the running division.
        @(negedge clk);
        start = 1'b1;
        precof = 19'd705;
        centimos = 12'd470;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_w", weightInGrams, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bok = 1'b1;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bok = 1'b0;
        end
        chk("midrst_quiet", bok, 1);
        run_op(19'd705, 12'd470, lat, bok);
        chk("post_rst_lat", lat, 31);
        chk("post_rst_w", weightInGrams, 1500);
        chk("post_rst_ovf", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
